// File: rtl/hq_frame_scheduler.sv
// Per-second frame scheduler: keeps week/time-of-week, launches one encoder frame per
// epoch pulse, and flags overruns, encoder timeouts and a missing PPS.
module hq_frame_scheduler #(
    parameter int TOW_MAX      = 604799,
    parameter int PPS_TIMEOUT  = 150000000,
    parameter int DONE_TIMEOUT = 90000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        time_wr,
    input  logic [9:0]  wn10,
    input  logic [19:0] tow_sec,
    input  logic        enc_busy,
    input  logic        enc_done,
    output logic        enc_load,
    output logic [9:0]  enc_wn10,
    output logic [19:0] enc_tow,
    output logic        time_valid,
    output logic        overrun,
    output logic        enc_timeout,
    output logic        pps_lost,
    output logic [15:0] frame_cnt
);
    localparam int PPS_W  = $clog2(PPS_TIMEOUT + 1);
    localparam int DONE_W = $clog2(DONE_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ARMED, LAUNCH, WAIT_DONE} state_t;

    state_t              state_reg;
    logic [9:0]          cur_wn_reg;
    logic [19:0]         cur_tow_reg;
    logic [PPS_W-1:0]    pps_cnt_reg;
    logic [DONE_W-1:0]   done_cnt_reg;

    logic wr_ok;
    logic start_ok;

    assign wr_ok    = time_wr && (tow_sec <= 20'(TOW_MAX));
    assign start_ok = start && time_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            cur_wn_reg   <= '0;
            cur_tow_reg  <= '0;
            pps_cnt_reg  <= '0;
            done_cnt_reg <= '0;
            enc_load     <= 1'b0;
            enc_wn10     <= '0;
            enc_tow      <= '0;
            time_valid   <= 1'b0;
            overrun      <= 1'b0;
            enc_timeout  <= 1'b0;
            pps_lost     <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            enc_load <= 1'b0;

            if (start) begin
                pps_cnt_reg <= '0;
                pps_lost    <= 1'b0;
            end else if (time_valid && pps_cnt_reg != PPS_W'(PPS_TIMEOUT)) begin
                pps_cnt_reg <= pps_cnt_reg + 1'b1;
                if (pps_cnt_reg == PPS_W'(PPS_TIMEOUT - 1))
                    pps_lost <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (wr_ok)
                        state_reg <= ARMED;
                end
                ARMED: begin
                    if (start_ok && !enc_busy) begin
                        state_reg    <= LAUNCH;
                        enc_load     <= 1'b1;
                        enc_wn10     <= cur_wn_reg;
                        enc_tow      <= cur_tow_reg;
                        frame_cnt    <= frame_cnt + 1'b1;
                        done_cnt_reg <= '0;
                    end
                end
                LAUNCH: begin
                    state_reg    <= WAIT_DONE;
                    done_cnt_reg <= done_cnt_reg + 1'b1;
                end
                WAIT_DONE: begin
                    if (enc_done) begin
                        state_reg <= ARMED;
                    end else if (done_cnt_reg == DONE_W'(DONE_TIMEOUT)) begin
                        enc_timeout <= 1'b1;
                        state_reg   <= ARMED;
                    end else begin
                        done_cnt_reg <= done_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // A start that cannot launch: encoder busy, or a frame is still in flight.
            if (start_ok && (state_reg != ARMED || enc_busy))
                overrun <= 1'b1;

            if (start_ok) begin
                if (cur_tow_reg == 20'(TOW_MAX)) begin
                    cur_tow_reg <= '0;
                    cur_wn_reg  <= cur_wn_reg + 1'b1;
                end else begin
                    cur_tow_reg <= cur_tow_reg + 1'b1;
                end
            end

            // Loading time takes priority over the advance and clears the sticky flags.
            if (wr_ok) begin
                cur_wn_reg  <= wn10;
                cur_tow_reg <= tow_sec;
                time_valid  <= 1'b1;
                overrun     <= 1'b0;
                enc_timeout <= 1'b0;
            end
        end
    end
endmodule
